// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline control unit.
//   - Stage index constants: index 0 is IF (youngest), higher index is older.
//   - cnt_width(): width of an outstanding-request counter able to hold
//     0..max_outstanding.
// No ports.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EXE = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   localparam int N_STAGES_DEF        = 5;
   localparam int MAX_OUTSTANDING_DEF = 2;

   // A counter must reach max_outstanding itself, hence the +1.
   function automatic int cnt_width(input int max_outstanding);
      return (max_outstanding < 1) ? 1 : $clog2(max_outstanding + 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the pipeline request/control vectors and both sram-like channel
// handshakes seen by pipe_ctrl.
//   slave  modport : used by pipe_ctrl (takes requests and bus handshakes,
//                    drives stall/flush/bubble, gated requests and status).
//   master modport : used by whatever drives the requests (hazard unit,
//                    stage logic, bus model or testbench).
// Signals:
//   stall_req, flush_req [N_STAGES]  per-stage requests
//   inst_want, data_want             stage wants / waits on a bus request
//   *_addr_ok, *_data_ok             sram-like handshake from the bus
//   stall, flush, bubble [N_STAGES]  per-stage register controls
//   inst_req, data_req               gated requests to the bus
//   inst_discard                     current inst return belongs to a flushed fetch
//   inst_busy, data_busy             channel has outstanding requests
//   protocol_err                     sticky unexpected-return flag
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
   parameter int N_STAGES = 5
) ();

   logic [N_STAGES-1:0] stall_req;
   logic [N_STAGES-1:0] flush_req;
   logic                inst_want;
   logic                data_want;
   logic                inst_addr_ok;
   logic                inst_data_ok;
   logic                data_addr_ok;
   logic                data_data_ok;

   logic [N_STAGES-1:0] stall;
   logic [N_STAGES-1:0] flush;
   logic [N_STAGES-1:0] bubble;
   logic                inst_req;
   logic                data_req;
   logic                inst_discard;
   logic                inst_busy;
   logic                data_busy;
   logic                protocol_err;

   modport slave (
      input  stall_req, flush_req, inst_want, data_want,
             inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
      output stall, flush, bubble, inst_req, data_req, inst_discard,
             inst_busy, data_busy, protocol_err
   );

   modport master (
      output stall_req, flush_req, inst_want, data_want,
             inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
      input  stall, flush, bubble, inst_req, data_req, inst_discard,
             inst_busy, data_busy, protocol_err
   );

endinterface

// File: rtl/pipe_ctrl_req_tracker.sv
// -----------------------------------------------------------------------------
// req_tracker
// Outstanding-request bookkeeping for one sram-like channel.
//   - Gates the stage's request so no more than MAX_OUTSTANDING requests are
//     accepted but not yet returned.
//   - Counts accepts (req & addr_ok) and returns (data_ok with count != 0).
//   - With HAS_DISCARD, remembers how many in-flight requests were killed by
//     a flush so their returns can be marked as discarded.
//   - Flags a sticky protocol error on a return with nothing outstanding.
// Ports:
//   i_clk, i_rstn       clock, asynchronous active-low reset
//   i_want              stage wants to issue or is waiting on data
//   i_addr_ok, i_data_ok  bus handshake
//   i_flush             stage owning this channel is being flushed
//   o_req               gated request to the bus
//   o_wait              stage must stall (wants, but no live data this cycle)
//   o_discard           this cycle's data_ok belongs to a flushed request
//   o_busy              at least one request outstanding
//   o_err               sticky protocol error
// -----------------------------------------------------------------------------
module req_tracker
   import pipe_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter bit HAS_DISCARD     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_want,
   input  logic i_addr_ok,
   input  logic i_data_ok,
   input  logic i_flush,
   output logic o_req,
   output logic o_wait,
   output logic o_discard,
   output logic o_busy,
   output logic o_err
);

   localparam int            CW    = cnt_width(MAX_OUTSTANDING);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_disc;
   logic          r_err;
   logic          r_armed;

   logic [CW-1:0] w_cnt_next;
   logic [CW-1:0] w_disc_next;
   logic          w_acc;
   logic          w_ret;
   logic          w_disc_nz;
   logic          w_stray;

   // Request is held low at saturation and during reset.
   assign o_req = i_rstn & i_want & (r_cnt < C_MAX);

   assign w_acc = o_req & i_addr_ok;
   // A return with nothing outstanding never moves the counter below zero.
   assign w_ret = i_data_ok & (r_cnt != '0);

   assign w_cnt_next = r_cnt + CW'(w_acc) - CW'(w_ret);

   // disc never exceeds cnt, so disc != 0 implies the return is counted.
   assign w_disc_nz = (r_disc != '0);

   // A flush in the same cycle as a return also kills that return.
   assign o_discard = HAS_DISCARD & i_rstn & i_data_ok & (w_disc_nz | i_flush);

   // Reload (not accumulate) on flush: everything still in flight after this
   // cycle belongs to the killed path.
   assign w_disc_next = !HAS_DISCARD ? '0 :
                        i_flush      ? w_cnt_next :
                                       r_disc - CW'(i_data_ok & w_disc_nz);

   assign o_wait = i_want & ~(i_data_ok & ~o_discard);
   assign o_busy = (r_cnt != '0);
   assign o_err  = r_err;

   // Returns arriving after a reset but before the first new accept belong
   // to pre-reset traffic; they are ignored rather than reported.
   assign w_stray = i_data_ok & (r_cnt == '0) & r_armed;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt   <= '0;
         r_disc  <= '0;
         r_err   <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_next;
         r_disc  <= w_disc_next;
         r_err   <= r_err | w_stray;
         r_armed <= r_armed | w_acc;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// N-stage pipeline control: per-stage stall, flush and bubble generation plus
// outstanding-request tracking on the instruction (IF) and data (MEM_STAGE)
// channels, so those stages stall until their data returns.
// Ports:
//   i_clk   core clock
//   i_rstn  asynchronous active-low reset; while low, stall/flush are all
//           ones and every other output is 0
//   bus     pipe_ctrl_if.slave: requests, handshakes and all control outputs
// Stall is a prefix-OR from old to young: an older stall freezes every younger
// stage. Flush from stage k kills all stages below k, but only when stage k
// itself advances.
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int N_STAGES        = N_STAGES_DEF,
   parameter int MEM_STAGE       = STG_MEM,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   pipe_ctrl_if.slave bus
);

   logic                w_inst_wait;
   logic                w_data_wait;
   logic                w_inst_discard;
   logic                w_inst_err;
   logic                w_data_err;
   logic                w_unused_data_discard;

   // Stall prefix-OR ignoring the IF fetch wait. Kept separate so the
   // fetch-wait -> discard -> flush[0] path cannot form a combinational loop:
   // flush only ever looks at stall of stages >= 1, which do not depend on
   // the IF wait.
   logic [N_STAGES-1:0] w_stall_old;
   logic [N_STAGES-1:0] w_flush_raw;
   logic [N_STAGES-1:0] w_stall;
   logic [N_STAGES-1:0] w_flush;
   logic [N_STAGES-1:0] w_bubble;

   always_comb begin
      w_stall_old = '0;
      w_flush_raw = '0;
      w_stall_old[N_STAGES-1] = bus.stall_req[N_STAGES-1]
                              | (((N_STAGES-1) == MEM_STAGE) && w_data_wait);
      for (int i = N_STAGES-2; i >= 0; i--) begin
         w_stall_old[i] = bus.stall_req[i]
                        | ((i == MEM_STAGE) && w_data_wait)
                        | w_stall_old[i+1];
         w_flush_raw[i] = w_flush_raw[i+1]
                        | (bus.flush_req[i+1] & ~w_stall_old[i+1]);
      end
   end

   assign w_stall = i_rstn ? {w_stall_old[N_STAGES-1:1], w_stall_old[0] | w_inst_wait}
                           : '1;
   assign w_flush = i_rstn ? w_flush_raw : '1;

   // A bubble enters stage i+1 when the stage below it holds but stage i+1
   // drains; a flushed stage is already a bubble.
   assign w_bubble[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < N_STAGES-1; gi++) begin : g_bubble
         assign w_bubble[gi+1] = i_rstn & w_stall[gi] & ~w_stall[gi+1] & ~w_flush[gi+1];
      end
   endgenerate

   req_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .HAS_DISCARD     (1'b1)
   ) u_inst_trk (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_want    (bus.inst_want),
      .i_addr_ok (bus.inst_addr_ok),
      .i_data_ok (bus.inst_data_ok),
      .i_flush   (w_flush[STG_IF]),
      .o_req     (bus.inst_req),
      .o_wait    (w_inst_wait),
      .o_discard (w_inst_discard),
      .o_busy    (bus.inst_busy),
      .o_err     (w_inst_err)
   );

   // Loads and stores always complete once accepted, so the data channel
   // never discards and a MEM flush does not touch its counter.
   req_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .HAS_DISCARD     (1'b0)
   ) u_data_trk (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_want    (bus.data_want),
      .i_addr_ok (bus.data_addr_ok),
      .i_data_ok (bus.data_data_ok),
      .i_flush   (1'b0),
      .o_req     (bus.data_req),
      .o_wait    (w_data_wait),
      .o_discard (w_unused_data_discard),
      .o_busy    (bus.data_busy),
      .o_err     (w_data_err)
   );

   assign bus.stall        = w_stall;
   assign bus.flush        = w_flush;
   assign bus.bubble       = w_bubble;
   assign bus.inst_discard = w_inst_discard;
   assign bus.protocol_err = w_inst_err | w_data_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl (N_STAGES=5, MEM_STAGE=3, MAX_OUTSTANDING=2).
// Each step drives inputs on the falling edge, pushes the hand-derived
// expected outputs onto a scoreboard queue, and pops/compares them once the
// combinational outputs have settled, well before the next rising edge.
// misc = {inst_req, data_req, inst_discard, inst_busy, data_busy, protocol_err}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic clk;
   logic rstn;

   int n_chk = 0;
   int n_err = 0;

   pipe_ctrl_if #(.N_STAGES(5)) bus ();

   pipe_ctrl #(
      .N_STAGES        (5),
      .MEM_STAGE       (3),
      .MAX_OUTSTANDING (2)
   ) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      tag;
      logic [4:0] stall;
      logic [4:0] flush;
      logic [4:0] bubble;
      logic [5:0] misc;
   } exp_t;

   exp_t sb_q[$];

   task automatic drive(input logic [4:0] sr, input logic [4:0] fr,
                        input logic iw, input logic iao, input logic ido,
                        input logic dw, input logic dao, input logic ddo);
      bus.stall_req    = sr;
      bus.flush_req    = fr;
      bus.inst_want    = iw;
      bus.inst_addr_ok = iao;
      bus.inst_data_ok = ido;
      bus.data_want    = dw;
      bus.data_addr_ok = dao;
      bus.data_data_ok = ddo;
   endtask

   task automatic exp_now(input string tag, input logic [4:0] st, input logic [4:0] fl,
                          input logic [4:0] bu, input logic [5:0] mi);
      exp_t       e;
      logic [5:0] act_misc;
      e.tag = tag; e.stall = st; e.flush = fl; e.bubble = bu; e.misc = mi;
      sb_q.push_back(e);
      #2;
      e = sb_q.pop_front();
      act_misc = {bus.inst_req, bus.data_req, bus.inst_discard,
                  bus.inst_busy, bus.data_busy, bus.protocol_err};
      n_chk++;
      assert (bus.stall === e.stall) else begin
         n_err++;
         $error("FAIL %s stall got %b exp %b", e.tag, bus.stall, e.stall);
      end
      n_chk++;
      assert (bus.flush === e.flush) else begin
         n_err++;
         $error("FAIL %s flush got %b exp %b", e.tag, bus.flush, e.flush);
      end
      n_chk++;
      assert (bus.bubble === e.bubble) else begin
         n_err++;
         $error("FAIL %s bubble got %b exp %b", e.tag, bus.bubble, e.bubble);
      end
      n_chk++;
      assert (act_misc === e.misc) else begin
         n_err++;
         $error("FAIL %s misc got %b exp %b", e.tag, act_misc, e.misc);
      end
      $display("%-14s stall=%b flush=%b bubble=%b misc=%b", e.tag,
               bus.stall, bus.flush, bus.bubble, act_misc);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      // Reset state, with requests present that must stay gated off.
      rstn = 1'b0;
      drive(5'b00000, 5'b00000, 1, 1, 1, 1, 1, 1);
      exp_now("reset", 5'b11111, 5'b11111, 5'b00000, 6'b000000);

      tick(); rstn = 1'b1;
      drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("idle", 5'b00000, 5'b00000, 5'b00000, 6'b000000);

      // Stall / flush / bubble prefix logic.
      tick(); drive(5'b00010, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("id_stall", 5'b00011, 5'b00000, 5'b00100, 6'b000000);
      tick(); drive(5'b00000, 5'b00010, 0, 0, 0, 0, 0, 0);
      exp_now("id_flush", 5'b00000, 5'b00001, 5'b00000, 6'b000000);
      tick(); drive(5'b00100, 5'b00010, 0, 0, 0, 0, 0, 0);
      exp_now("id_flush_exst", 5'b00111, 5'b00000, 5'b01000, 6'b000000);
      tick(); drive(5'b00000, 5'b10000, 0, 0, 0, 0, 0, 0);
      exp_now("wb_flush", 5'b00000, 5'b01111, 5'b00000, 6'b000000);
      tick(); drive(5'b00100, 5'b01000, 0, 0, 0, 0, 0, 0);
      exp_now("mem_flush_ovr", 5'b00111, 5'b00111, 5'b01000, 6'b000000);

      // Inst channel saturation: two accepts, then request held low.
      tick(); drive(5'b00000, 5'b00000, 1, 1, 0, 0, 0, 0);
      exp_now("isat_acc1", 5'b00001, 5'b00000, 5'b00010, 6'b100000);
      tick();
      exp_now("isat_acc2", 5'b00001, 5'b00000, 5'b00010, 6'b100100);
      tick();
      exp_now("isat_full", 5'b00001, 5'b00000, 5'b00010, 6'b000100);

      // Flush IF with two fetches in flight; both returns are discarded.
      tick(); drive(5'b00000, 5'b00010, 1, 0, 0, 0, 0, 0);
      exp_now("iflush", 5'b00001, 5'b00001, 5'b00010, 6'b000100);
      tick(); drive(5'b00000, 5'b00000, 1, 0, 1, 0, 0, 0);
      exp_now("idisc1", 5'b00001, 5'b00000, 5'b00010, 6'b001100);
      tick(); drive(5'b00000, 5'b00000, 1, 1, 1, 0, 0, 0);
      exp_now("idisc2_acc", 5'b00001, 5'b00000, 5'b00010, 6'b101100);
      tick(); drive(5'b00000, 5'b00000, 1, 0, 1, 0, 0, 0);
      exp_now("ilive", 5'b00000, 5'b00000, 5'b00000, 6'b100100);
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("idrained", 5'b00000, 5'b00000, 5'b00000, 6'b000000);

      // Data channel wait; a WB flush mid-wait must not cancel the return.
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 1, 1, 0);
      exp_now("dwait1", 5'b01111, 5'b00000, 5'b10000, 6'b010000);
      tick(); drive(5'b00000, 5'b10000, 0, 0, 0, 1, 0, 0);
      exp_now("dwait2_flush", 5'b01111, 5'b01111, 5'b10000, 6'b010010);
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 1, 0, 1);
      exp_now("dreturn", 5'b00000, 5'b00000, 5'b00000, 6'b010010);
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("ddrained", 5'b00000, 5'b00000, 5'b00000, 6'b000000);

      // Stray data return with nothing outstanding sets the sticky error.
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 1);
      exp_now("dstray", 5'b00000, 5'b00000, 5'b00000, 6'b000000);
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("perr_set", 5'b00000, 5'b00000, 5'b00000, 6'b000001);
      tick();
      exp_now("perr_sticky", 5'b00000, 5'b00000, 5'b00000, 6'b000001);

      // Reset mid-operation with one fetch outstanding.
      tick(); drive(5'b00000, 5'b00000, 1, 1, 0, 0, 0, 0);
      exp_now("rst_pre_acc", 5'b00001, 5'b00000, 5'b00010, 6'b100001);
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("rst_pre_busy", 5'b00000, 5'b00000, 5'b00000, 6'b000101);
      tick(); #1 rstn = 1'b0;
      exp_now("rst_async", 5'b11111, 5'b11111, 5'b00000, 6'b000000);
      tick(); rstn = 1'b1;
      drive(5'b00000, 5'b00000, 0, 0, 1, 0, 0, 0);
      exp_now("rst_stray", 5'b00000, 5'b00000, 5'b00000, 6'b000000);
      tick(); drive(5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0);
      exp_now("rst_no_err", 5'b00000, 5'b00000, 5'b00000, 6'b000000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
